mem_access_unit: RTL and testbench

- Sequential load/store unit for the RISC-V pipeline MEM stage. Consumes the load size/sign and store controls produced by instruction decode.
- Performs byte-lane alignment, byte-enable generation and sign/zero extension.
- Drives a valid/ready data-memory port with one outstanding transaction and stalls the pipeline while busy.
- Generalised to XLEN 32/64; misaligned-access handling is selectable.

---
 rtl/mem_pkg.sv | 30 +++
 rtl/lsu_align.sv | 71 +++++++
 rtl/mem_access_unit.sv | 159 +++++++++++++++
 tb/tb_mem_access_unit.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types for the MEM-stage load/store unit: access sizes, FSM states
// and the access-size-to-byte-count helper.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_WORD  = 2'b00,
        SZ_HALF  = 2'b01,
        SZ_BYTE  = 2'b10,
        SZ_DWORD = 2'b11
    } mem_size_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ1  = 3'd1,
        ST_WAIT1 = 3'd2,
        ST_REQ2  = 3'd3,
        ST_WAIT2 = 3'd4,
        ST_RESP  = 3'd5
    } lsu_state_t;

    function automatic logic [3:0] size_bytes(input mem_size_t sz);
        case (sz)
            SZ_WORD:  return 4'd4;
            SZ_HALF:  return 4'd2;
            SZ_BYTE:  return 4'd1;
            default:  return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering for the load/store unit: byte enables and
// write-data shifts for both beats, plus read merge and sign/zero extension.
module lsu_align
    import mem_pkg::*;
#(
    parameter  int XLEN = 32,
    localparam int NB   = XLEN / 8,
    localparam int OFFW = $clog2(NB)
) (
    input  mem_size_t         i_size,
    input  logic              i_signed,
    input  logic [OFFW-1:0]   i_off,
    input  logic              i_cross,
    input  logic [XLEN-1:0]   i_wdata,
    input  logic [XLEN-1:0]   i_rd1,
    input  logic [XLEN-1:0]   i_rd2,
    output logic [NB-1:0]     o_be1,
    output logic [NB-1:0]     o_be2,
    output logic [XLEN-1:0]   o_wdata1,
    output logic [XLEN-1:0]   o_wdata2,
    output logic [XLEN-1:0]   o_rdata
);

    logic [2*NB-1:0]  w_mask;
    logic [2*NB-1:0]  w_be_full;
    logic [OFFW+3:0]  w_sh_lo;
    logic [OFFW+3:0]  w_sh_hi;
    logic [XLEN-1:0]  w_rd2_m;
    logic [XLEN-1:0]  w_merged;

    // Keep the low n bytes; fill the rest with the sign bit or zeros.
    function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] v,
                                               input mem_size_t sz,
                                               input logic sgn);
        logic [XLEN-1:0] m;
        logic            sb;
        case (sz)
            SZ_BYTE: begin m = XLEN'(8'hFF);         sb = v[7];  end
            SZ_HALF: begin m = XLEN'(16'hFFFF);      sb = v[15]; end
            SZ_WORD: begin m = XLEN'(32'hFFFF_FFFF); sb = v[31]; end
            default: begin m = '1;                   sb = 1'b0;  end
        endcase
        return (v & m) | ({XLEN{sgn & sb}} & ~m);
    endfunction

    always_comb begin
        w_mask = '0;
        case (i_size)
            SZ_BYTE: w_mask = (2*NB)'(8'h01);
            SZ_HALF: w_mask = (2*NB)'(8'h03);
            SZ_WORD: w_mask = (2*NB)'(8'h0F);
            default: w_mask = (2*NB)'(8'hFF);
        endcase
    end

    // Lanes that spill past the bus word land in the upper half: beat 2's lanes.
    assign w_be_full = w_mask << i_off;
    assign o_be1     = w_be_full[NB-1:0];
    assign o_be2     = w_be_full[2*NB-1:NB];

    assign w_sh_lo   = {1'b0, i_off, 3'b000};
    assign w_sh_hi   = (OFFW+4)'(XLEN) - w_sh_lo;

    assign o_wdata1  = i_wdata << w_sh_lo;
    assign o_wdata2  = i_wdata >> w_sh_hi;

    assign w_rd2_m   = i_cross ? i_rd2 : {XLEN{1'b0}};
    assign w_merged  = (i_rd1 >> w_sh_lo) | (w_rd2_m << w_sh_hi);
    assign o_rdata   = extend(w_merged, i_size, i_signed);

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: one outstanding valid/ready memory transaction,
// optional two-beat split of misaligned accesses under MISALIGNED_SPLIT_EN.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter  int XLEN   = 32,
    parameter  int ADDR_W = 32,
    localparam int NB     = XLEN / 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [NB-1:0]     mem_be,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_misaligned,
    output logic              busy
);

    localparam int OFFW = $clog2(NB);

    lsu_state_t        r_state;
    lsu_state_t        w_next;
    logic              r_we;
    logic              r_err;
    logic              r_cross;
    mem_size_t         r_size;
    logic              r_signed;
    logic [ADDR_W-1:0] r_addr;
    logic [XLEN-1:0]   r_wdata;
    logic [XLEN-1:0]   r_rd1;
    logic [XLEN-1:0]   r_rd2;

    logic              w_accept;
    mem_size_t         w_in_size;
    logic [3:0]        w_in_n;
    logic [3:0]        w_in_off;
    logic              w_in_cross;
    logic              w_in_illegal;
    logic              w_in_err;
    logic              w_split;
    logic              w_beat2;
    logic [ADDR_W-1:0] w_addr1;
    logic [ADDR_W-1:0] w_addr2;
    logic [NB-1:0]     w_be1;
    logic [NB-1:0]     w_be2;
    logic [XLEN-1:0]   w_wdata1;
    logic [XLEN-1:0]   w_wdata2;
    logic [XLEN-1:0]   w_ld_data;

    assign w_accept     = req_valid && (r_state == ST_IDLE);
    assign w_in_size    = mem_size_t'(req_size);
    assign w_in_n       = size_bytes(w_in_size);
    assign w_in_off     = 4'(req_addr[OFFW-1:0]);
    assign w_in_cross   = (w_in_off + w_in_n) > 4'(NB);
    assign w_in_illegal = (XLEN == 32) && (w_in_size == SZ_DWORD);

`ifdef MISALIGNED_SPLIT_EN
    assign w_in_err     = w_in_illegal;
    assign w_split      = r_cross;
`else
    logic w_in_misal;
    assign w_in_misal   = (w_in_off & (w_in_n - 4'd1)) != 4'd0;
    assign w_in_err     = w_in_illegal || w_in_misal;
    assign w_split      = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_cross <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_we    <= req_we;
                r_err   <= w_in_err;
                r_cross <= w_in_cross;
            end
        end
    end

    // Request payload and returned read beats; output gating keeps these
    // invisible outside the states that use them.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_size   <= w_in_size;
            r_signed <= req_signed;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
        end
        if ((r_state == ST_WAIT1) && mem_rvalid) r_rd1 <= mem_rdata;
        if ((r_state == ST_WAIT2) && mem_rvalid) r_rd2 <= mem_rdata;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (req_valid)  w_next = w_in_err ? ST_RESP : ST_REQ1;
            ST_REQ1:  if (mem_ready) begin
                          if (!r_we)  w_next = ST_WAIT1;
                          else        w_next = w_split ? ST_REQ2 : ST_RESP;
                      end
            ST_WAIT1: if (mem_rvalid) w_next = w_split ? ST_REQ2 : ST_RESP;
            ST_REQ2:  if (mem_ready)  w_next = r_we ? ST_RESP : ST_WAIT2;
            ST_WAIT2: if (mem_rvalid) w_next = ST_RESP;
            ST_RESP:                  w_next = ST_IDLE;
            default:                  w_next = ST_IDLE;
        endcase
    end

    lsu_align #(
        .XLEN (XLEN)
    ) u_align (
        .i_size   (r_size),
        .i_signed (r_signed),
        .i_off    (r_addr[OFFW-1:0]),
        .i_cross  (w_split),
        .i_wdata  (r_wdata),
        .i_rd1    (r_rd1),
        .i_rd2    (r_rd2),
        .o_be1    (w_be1),
        .o_be2    (w_be2),
        .o_wdata1 (w_wdata1),
        .o_wdata2 (w_wdata2),
        .o_rdata  (w_ld_data)
    );

    assign w_beat2   = (r_state == ST_REQ2);
    assign w_addr1   = {r_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
    assign w_addr2   = w_addr1 + ADDR_W'(NB);

    assign mem_valid = (r_state == ST_REQ1) || (r_state == ST_REQ2);
    assign mem_we    = mem_valid && r_we;
    assign mem_addr  = mem_valid ? (w_beat2 ? w_addr2  : w_addr1)  : '0;
    assign mem_be    = mem_valid ? (w_beat2 ? w_be2    : w_be1)    : '0;
    assign mem_wdata = mem_valid ? (w_beat2 ? w_wdata2 : w_wdata1) : '0;

    assign req_ready      = (r_state == ST_IDLE);
    assign busy           = (r_state != ST_IDLE);
    assign rsp_valid      = (r_state == ST_RESP);
    assign rsp_misaligned = rsp_valid && r_err;
    assign rsp_rdata      = (rsp_valid && !r_we && !r_err) ? w_ld_data : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit (XLEN=32); expectations follow
// MISALIGNED_SPLIT_EN when the bench is built with it defined.
module tb_mem_access_unit;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_misaligned;
    logic        busy;

    mem_access_unit #(.XLEN(32), .ADDR_W(32)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_size       (req_size),
        .req_signed     (req_signed),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_be         (mem_be),
        .mem_wdata      (mem_wdata),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_misaligned (rsp_misaligned),
        .busy           (busy)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        int          exp_cyc;
        string       nm;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
        int          rv_delay;
        string       nm;
    } beat_t;

    rsp_t  rsp_q[$];
    beat_t beat_q[$];
    int    checks   = 0;
    int    failures = 0;
    int    cyc      = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        failures++;
        $display("FAIL %s", nm);
    endtask

    task automatic push_beat(input logic [31:0] a, input logic [3:0] be, input logic we,
                             input logic [31:0] wd, input logic [31:0] rd,
                             input int dly, input int rvd, input string nm);
        beat_t b;
        b.addr = a; b.be = be; b.we = we; b.wdata = wd; b.rdata = rd;
        b.delay = dly; b.rv_delay = rvd; b.nm = nm;
        beat_q.push_back(b);
    endtask

    // Memory model: checks every presented beat (each cycle, so held
    // requests are checked for stability) and returns read data.
    initial begin
        beat_t       b;
        int          held = 0;
        int          pend = 0;
        logic [31:0] pend_data = '0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge clk);
            mem_ready  = 1'b0;
            mem_rvalid = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = pend_data;
                end
            end
            if (mem_valid) begin
                if (beat_q.size() == 0) begin
                    fail($sformatf("unexpected_mem_valid addr=%h", mem_addr));
                end else begin
                    b = beat_q[0];
                    chk({b.nm, "_addr"}, mem_addr, b.addr);
                    chk({b.nm, "_be"}, {28'd0, mem_be}, {28'd0, b.be});
                    chk({b.nm, "_we"}, {31'd0, mem_we}, {31'd0, b.we});
                    if (b.we) chk({b.nm, "_wdata"}, mem_wdata, b.wdata);
                    if (held < b.delay) begin
                        held++;
                    end else begin
                        held = 0;
                        mem_ready = 1'b1;
                        void'(beat_q.pop_front());
                        if (!b.we) begin
                            pend      = b.rv_delay;
                            pend_data = b.rdata;
                        end
                    end
                end
            end
        end
    end

    // Response monitor
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    fail($sformatf("unexpected_rsp rdata=%h mis=%0d", rsp_rdata, rsp_misaligned));
                end else begin
                    e = rsp_q.pop_front();
                    chk({e.nm, "_rdata"}, rsp_rdata, e.rdata);
                    chk({e.nm, "_mis"}, {31'd0, rsp_misaligned}, {31'd0, e.mis});
                    chk({e.nm, "_cycle"}, cyc, e.exp_cyc);
                    chk({e.nm, "_busy_resp"}, {31'd0, busy}, 32'd1);
                end
            end
        end
    end

    task automatic issue(input logic we, input logic [1:0] sz, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_mis,
                         input int lat, input string nm);
        rsp_t e;
        int   n;
        @(negedge clk);
        chk({nm, "_req_ready_idle"}, {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = sz;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wd;
        e.rdata = exp_rd; e.mis = exp_mis; e.exp_cyc = cyc + lat; e.nm = nm;
        rsp_q.push_back(e);
        @(negedge clk);
        req_valid  = 1'b0;
        req_we     = ~we;
        req_size   = 2'b10;
        req_signed = ~sgn;
        req_addr   = 32'hFFFF_FFF0;
        req_wdata  = ~wd;
        chk({nm, "_busy_t1"}, {31'd0, busy}, 32'd1);
        chk({nm, "_req_ready_t1"}, {31'd0, req_ready}, 32'd0);
        n = 0;
        while (!rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) fail({nm, "_timeout"});
        @(negedge clk);
        chk({nm, "_busy_after"}, {31'd0, busy}, 32'd0);
        chk({nm, "_req_ready_after"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        repeat (3) @(negedge clk);
        chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_mis", {31'd0, rsp_misaligned}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);

        push_beat(32'h100, 4'b1111, 1'b0, 32'h0, 32'hDEADBEEF, 0, 1, "lw100");
        issue(1'b0, 2'b00, 1'b1, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 3, "lw100");

        push_beat(32'h100, 4'b1000, 1'b0, 32'h0, 32'h80123456, 0, 1, "lb103");
        issue(1'b0, 2'b10, 1'b1, 32'h103, 32'h0, 32'hFFFFFF80, 1'b0, 3, "lb103");
        push_beat(32'h100, 4'b1000, 1'b0, 32'h0, 32'h80123456, 0, 1, "lbu103");
        issue(1'b0, 2'b10, 1'b0, 32'h103, 32'h0, 32'h00000080, 1'b0, 3, "lbu103");

        push_beat(32'h100, 4'b1100, 1'b1, 32'hABCD0000, 32'h0, 0, 1, "sh102");
        issue(1'b1, 2'b01, 1'b0, 32'h102, 32'h0000ABCD, 32'h0, 1'b0, 2, "sh102");

        push_beat(32'h100, 4'b1100, 1'b0, 32'h0, 32'h80010000, 0, 1, "lh102");
        issue(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 32'hFFFF8001, 1'b0, 3, "lh102");
        push_beat(32'h100, 4'b1100, 1'b0, 32'h0, 32'h80010000, 0, 1, "lhu102");
        issue(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 32'h00008001, 1'b0, 3, "lhu102");

        push_beat(32'h100, 4'b0010, 1'b1, 32'h0000A500, 32'h0, 0, 1, "sb101");
        issue(1'b1, 2'b10, 1'b0, 32'h101, 32'h000000A5, 32'h0, 1'b0, 2, "sb101");

        issue(1'b0, 2'b11, 1'b1, 32'h100, 32'h0, 32'h0, 1'b1, 1, "ld_illegal");

        push_beat(32'h104, 4'b1111, 1'b1, 32'h12345678, 32'h0, 3, 1, "sw_wait");
        issue(1'b1, 2'b00, 1'b0, 32'h104, 32'h12345678, 32'h0, 1'b0, 5, "sw_wait");

`ifdef MISALIGNED_SPLIT_EN
        push_beat(32'h0FC, 4'b1100, 1'b0, 32'h0, 32'hAABB0000, 0, 1, "lw0fe_b1");
        push_beat(32'h100, 4'b0011, 1'b0, 32'h0, 32'h0000CCDD, 0, 1, "lw0fe_b2");
        issue(1'b0, 2'b00, 1'b1, 32'h0FE, 32'h0, 32'hCCDDAABB, 1'b0, 5, "lw0fe");

        push_beat(32'h100, 4'b0110, 1'b0, 32'h0, 32'h00ABCD00, 0, 1, "lh101");
        issue(1'b0, 2'b01, 1'b1, 32'h101, 32'h0, 32'hFFFFABCD, 1'b0, 3, "lh101");

        push_beat(32'h0FC, 4'b1110, 1'b1, 32'h22334400, 32'h0, 0, 1, "sw0fd_b1");
        push_beat(32'h100, 4'b0001, 1'b1, 32'h00000011, 32'h0, 0, 1, "sw0fd_b2");
        issue(1'b1, 2'b00, 1'b0, 32'h0FD, 32'h11223344, 32'h0, 1'b0, 3, "sw0fd");

        push_beat(32'hFFFFFFFC, 4'b1000, 1'b0, 32'h0, 32'h7F000000, 0, 1, "lhwrap_b1");
        push_beat(32'h00000000, 4'b0001, 1'b0, 32'h0, 32'h000000FF, 0, 1, "lhwrap_b2");
        issue(1'b0, 2'b01, 1'b1, 32'hFFFFFFFF, 32'h0, 32'hFFFFFF7F, 1'b0, 5, "lhwrap");
`else
        issue(1'b0, 2'b00, 1'b1, 32'h0FE, 32'h0, 32'h0, 1'b1, 1, "lw0fe");
        issue(1'b0, 2'b01, 1'b1, 32'h101, 32'h0, 32'h0, 1'b1, 1, "lh101");
        issue(1'b1, 2'b00, 1'b0, 32'h0FD, 32'h11223344, 32'h0, 1'b1, 1, "sw0fd");
        issue(1'b0, 2'b01, 1'b1, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b1, 1, "lhwrap");
`endif

        // Reset while waiting for read data; the late rvalid must be ignored.
        push_beat(32'h200, 4'b1111, 1'b0, 32'h0, 32'hCAFEF00D, 0, 4, "lw_rst");
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b1;
        req_addr   = 32'h200;
        @(negedge clk);
        req_valid  = 1'b0;
        chk("lw_rst_t1_mem_valid", {31'd0, mem_valid}, 32'd1);
        @(negedge clk);
        chk("lw_rst_wait_mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("lw_rst_wait_busy", {31'd0, busy}, 32'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("lw_rst_busy_drop", {31'd0, busy}, 32'd0);
        chk("lw_rst_mem_valid_drop", {31'd0, mem_valid}, 32'd0);
        chk("lw_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("lw_rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("lw_rst_busy_after", {31'd0, busy}, 32'd0);

        repeat (3) @(negedge clk);
        chk("beat_q_empty", beat_q.size(), 32'd0);
        chk("rsp_q_empty", rsp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
